bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator_if.sv | 27 ++
 rtl/bus_initiator.sv | 114 +++++++++++
 tb/tb_bus_initiator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bus_initiator_if.sv
// Core-side request/response and multiplexed memory-bus signals of the bus initiator.
// master is the initiator's view; slave is the core/responder view.
interface bus_initiator_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       pause;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       ALE;
  logic       En;
  logic       Rw;
  logic [7:0] Bus_Out;
  logic [7:0] Bus_In;

  modport master (
    input  req, we, addr, wdata, pause, Bus_In,
    output ready, done, rdata, ALE, En, Rw, Bus_Out
  );

  modport slave (
    output req, we, addr, wdata, pause, Bus_In,
    input  ready, done, rdata, ALE, En, Rw, Bus_Out
  );
endinterface

// File: rtl/bus_initiator.sv
// Multiplexed-bus initiator: runs one read or write per accepted request through
// IDLE -> ADDR -> DATA (-> CAPT) with every output registered.
module bus_initiator #(
  parameter int unsigned RD_WAIT = 0
) (
  input logic            clk,
  input logic            rst,
  bus_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CAPT = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT);

  state_t     state_reg;
  logic       we_reg;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic [2:0] wait_cnt_reg;

  logic       ready_reg;
  logic       done_reg;
  logic [7:0] rdata_reg;
  logic       ale_reg;
  logic       en_reg;
  logic       rw_reg;
  logic [7:0] bus_out_reg;

  // Outputs are loaded with the values of the state being entered, so they
  // line up exactly with state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      addr_reg     <= 8'h00;
      wdata_reg    <= 8'h00;
      wait_cnt_reg <= 3'd0;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
      rdata_reg    <= 8'h00;
      ale_reg      <= 1'b0;
      en_reg       <= 1'b0;
      rw_reg       <= 1'b0;
      bus_out_reg  <= 8'h00;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req && !bus.pause) begin
            we_reg      <= bus.we;
            addr_reg    <= bus.addr;
            wdata_reg   <= bus.wdata;
            state_reg   <= ADDR;
            ready_reg   <= 1'b0;
            ale_reg     <= 1'b1;
            en_reg      <= 1'b0;
            rw_reg      <= ~bus.we;
            bus_out_reg <= bus.addr;
          end
        end
        ADDR: begin
          state_reg   <= DATA;
          ale_reg     <= 1'b0;
          en_reg      <= 1'b1;
          rw_reg      <= ~we_reg;
          bus_out_reg <= we_reg ? wdata_reg : addr_reg;
        end
        DATA: begin
          en_reg <= 1'b0;
          if (we_reg) begin
            state_reg   <= IDLE;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b1;
            rw_reg      <= 1'b0;
            bus_out_reg <= 8'h00;
          end else begin
            state_reg    <= CAPT;
            rw_reg       <= 1'b1;
            bus_out_reg  <= addr_reg;
            wait_cnt_reg <= 3'd0;
          end
        end
        CAPT: begin
          // Bus_In is only looked at on the final capture edge.
          if (wait_cnt_reg == WAIT_LAST) begin
            rdata_reg   <= bus.Bus_In;
            state_reg   <= IDLE;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b1;
            rw_reg      <= 1'b0;
            bus_out_reg <= 8'h00;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_reg;
  assign bus.done    = done_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.ALE     = ale_reg;
  assign bus.En      = en_reg;
  assign bus.Rw      = rw_reg;
  assign bus.Bus_Out = bus_out_reg;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a small memory responder plus a second
// instance with RD_WAIT=2 for capture-latency checks.
module tb_bus_initiator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_initiator_if bus ();
  bus_initiator_if bus2 ();

  bus_initiator #(.RD_WAIT(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  bus_initiator #(.RD_WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Memory responder: latches the address under ALE, commits writes on the
  // edge ending the write data phase, drives read data while Rw is high.
  logic [7:0] mem [256];
  logic [7:0] addr_lat;
  always @(posedge clk) begin
    if (rst) mem[7] <= 8'hFD;
    if (bus.ALE) addr_lat <= bus.Bus_Out;
    if (bus.En && !bus.Rw) mem[addr_lat] <= bus.Bus_Out;
  end
  assign bus.Bus_In  = (bus.Rw && !bus.ALE) ? mem[addr_lat] : 8'hEE;
  assign bus2.Bus_In = (bus2.Rw && !bus2.ALE && !bus2.En) ? 8'hFD : 8'hEE;

  always @(negedge clk) begin
    if (!rst) begin
      check("ale_en_excl", {31'd0, bus.ALE & bus.En}, 32'd0);
      check("ale_en_excl2", {31'd0, bus2.ALE & bus2.En}, 32'd0);
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
  endtask

  int dcount;
  int dcyc1;
  int dcyc2;

  initial begin
    rst = 1'b1;
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.pause = 0;
    bus2.req = 0; bus2.we = 0; bus2.addr = 0; bus2.wdata = 0; bus2.pause = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_ale", {31'd0, bus.ALE}, 32'd0);
    check("rst_en", {31'd0, bus.En}, 32'd0);
    check("rst_rw", {31'd0, bus.Rw}, 32'd0);
    check("rst_busout", {24'd0, bus.Bus_Out}, 32'h00);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'h00);
    rst = 1'b0;

    // Write 61h to 04h
    issue(1'b1, 8'h04, 8'h61);
    @(negedge clk); bus.req = 0;
    $display("txn write 04<-61");
    check("wr_c1_ale", {31'd0, bus.ALE}, 32'd1);
    check("wr_c1_bus", {24'd0, bus.Bus_Out}, 32'h04);
    check("wr_c1_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    check("wr_c2_en", {31'd0, bus.En}, 32'd1);
    check("wr_c2_rw", {31'd0, bus.Rw}, 32'd0);
    check("wr_c2_bus", {24'd0, bus.Bus_Out}, 32'h61);
    @(negedge clk);
    check("wr_c3_done", {31'd0, bus.done}, 32'd1);
    check("wr_c3_mem", {24'd0, mem[4]}, 32'h61);
    check("wr_c3_idle_bus", {24'd0, bus.Bus_Out}, 32'h00);
    @(negedge clk);
    check("wr_c4_done", {31'd0, bus.done}, 32'd0);

    // Read 07h -> FDh
    issue(1'b0, 8'h07, 8'h00);
    @(negedge clk); bus.req = 0;
    $display("txn read 07");
    check("rd_c1_ale", {31'd0, bus.ALE}, 32'd1);
    check("rd_c1_rw", {31'd0, bus.Rw}, 32'd1);
    @(negedge clk);
    check("rd_c2_en", {31'd0, bus.En}, 32'd1);
    check("rd_c2_bus", {24'd0, bus.Bus_Out}, 32'h07);
    @(negedge clk);
    check("rd_c3_done", {31'd0, bus.done}, 32'd0);
    check("rd_c3_rdata", {24'd0, bus.rdata}, 32'h00);
    check("rd_c3_en", {31'd0, bus.En}, 32'd0);
    @(negedge clk);
    check("rd_c4_done", {31'd0, bus.done}, 32'd1);
    check("rd_c4_rdata", {24'd0, bus.rdata}, 32'hFD);

    // RD_WAIT=2 instance: done expected in cycle 6
    bus2.req = 1; bus2.we = 0; bus2.addr = 8'h07;
    dcyc1 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus2.req = 0;
      if (bus2.done && dcyc1 == 0) dcyc1 = c;
    end
    $display("txn read 07 RD_WAIT=2 done at cycle %0d", dcyc1);
    check("rw2_done_cyc", dcyc1, 32'd6);
    check("rw2_rdata", {24'd0, bus2.rdata}, 32'hFD);

    // Back-to-back: write 33h to 0Dh then read 0Dh with req held
    issue(1'b1, 8'h0D, 8'h33);
    dcount = 0; dcyc1 = 0; dcyc2 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.we = 0;
      if (c == 4) begin
        check("b2b_c4_ale", {31'd0, bus.ALE}, 32'd1);
        bus.req = 0;
      end
      if (bus.done) begin
        dcount++;
        if (dcyc1 == 0) dcyc1 = c; else dcyc2 = c;
      end
    end
    $display("txn b2b write/read 0D dones=%0d", dcount);
    check("b2b_dones", dcount, 32'd2);
    check("b2b_done1", dcyc1, 32'd3);
    check("b2b_done2", dcyc2, 32'd7);
    check("b2b_rdata", {24'd0, bus.rdata}, 32'h33);

    // Pause blocks acceptance; pause during DATA does not abort
    bus.pause = 1;
    issue(1'b0, 8'h04, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("pause_ready", {31'd0, bus.ready}, 32'd1);
      check("pause_ale", {31'd0, bus.ALE}, 32'd0);
    end
    bus.pause = 0;
    @(negedge clk); bus.req = 0;
    $display("txn paused read 04");
    check("pause_accept", {31'd0, bus.ALE}, 32'd1);
    @(negedge clk);
    check("pause_c2_en", {31'd0, bus.En}, 32'd1);
    bus.pause = 1;
    @(negedge clk);
    @(negedge clk);
    check("pause_done", {31'd0, bus.done}, 32'd1);
    check("pause_rdata", {24'd0, bus.rdata}, 32'h61);
    bus.pause = 0;

    // Reset during DATA of a read
    issue(1'b0, 8'h07, 8'h00);
    @(negedge clk); bus.req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    $display("txn read 07 aborted by reset");
    check("rst_mid_en", {31'd0, bus.En}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_mid_rdata", {24'd0, bus.rdata}, 32'h00);
    rst = 0;
    dcount = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("rst_mid_nodone", dcount, 32'd0);

    // Write 5Ah to 02h, then read 02h with addr changed while busy
    issue(1'b1, 8'h02, 8'h5A);
    @(negedge clk); bus.req = 0;
    @(negedge clk);
    @(negedge clk);
    $display("txn write 02<-5A");
    check("post_rst_wr_done", {31'd0, bus.done}, 32'd1);
    issue(1'b0, 8'h02, 8'h00);
    @(negedge clk); bus.req = 0; bus.addr = 8'h0F;
    @(negedge clk);
    check("busy_c2_bus", {24'd0, bus.Bus_Out}, 32'h02);
    @(negedge clk);
    check("busy_c3_bus", {24'd0, bus.Bus_Out}, 32'h02);
    @(negedge clk);
    $display("txn read 02 with addr changed while busy");
    check("busy_done", {31'd0, bus.done}, 32'd1);
    check("busy_rdata", {24'd0, bus.rdata}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
